// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: owns lives and level count, and turns the shoot
// button plus player/enemy event pulses into freeze, level-restart and
// end-of-game controls. Every output comes straight from a flop.
module game_flow_ctrl #(
  parameter int unsigned lives_p        = 3,
  parameter int unsigned levels_p       = 4,
  parameter int unsigned flash_cycles_p = 12_500_000
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       shoot_i,
  input  logic                       hit_i,
  input  logic                       cleared_i,
  input  logic                       invaded_i,
  output logic                       freeze_o,
  output logic                       level_reset_o,
  output logic [2:0]                 lives_o,
  output logic [$clog2(levels_p):0]  level_o,
  output logic                       alive_o,
  output logic                       ship_visible_o,
  output logic                       game_over_o,
  output logic                       game_won_o,
  output logic [5:0]                 state_o
);

  localparam int unsigned LivesW  = 3;
  localparam int unsigned LevelW  = $clog2(levels_p) + 1;
  localparam int unsigned FlashW  = (flash_cycles_p > 1) ? $clog2(flash_cycles_p) : 1;

  localparam logic [LivesW-1:0] LivesInit = LivesW'(lives_p);
  localparam logic [LevelW-1:0] LastLevel = LevelW'(levels_p - 1);
  localparam logic [FlashW-1:0] FlashLast = FlashW'(flash_cycles_p - 1);

  // One-hot encoding doubles as the debug state vector.
  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    PLAY      = 6'b000010,
    HIT_PAUSE = 6'b000100,
    LVL_DONE  = 6'b001000,
    OVER      = 6'b010000,
    WON       = 6'b100000
  } state_e;

  state_e              state_q, state_d;
  logic                shoot_q;
  logic [LivesW-1:0]   lives_q, lives_d;
  logic [LevelW-1:0]   level_q, level_d;
  logic [FlashW-1:0]   flash_q, flash_d;
  logic                vis_q, vis_d;
  logic                freeze_q, freeze_d;
  logic                lvl_rst_q, lvl_rst_d;
  logic                alive_q, alive_d;
  logic                over_q, over_d;
  logic                won_q, won_d;
  logic                press_c;

  // A press is a rising edge of the synchronised button level.
  assign press_c = shoot_i & ~shoot_q;

  // State register and all registered outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      shoot_q   <= 1'b1;
      lives_q   <= LivesInit;
      level_q   <= '0;
      flash_q   <= '0;
      vis_q     <= 1'b1;
      freeze_q  <= 1'b1;
      lvl_rst_q <= 1'b0;
      alive_q   <= 1'b1;
      over_q    <= 1'b0;
      won_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shoot_q   <= shoot_i;
      lives_q   <= lives_d;
      level_q   <= level_d;
      flash_q   <= flash_d;
      vis_q     <= vis_d;
      freeze_q  <= freeze_d;
      lvl_rst_q <= lvl_rst_d;
      alive_q   <= alive_d;
      over_q    <= over_d;
      won_q     <= won_d;
    end
  end

  // Next-state logic with lives/level bookkeeping; PLAY events are
  // prioritised invaded > hit > cleared, lower ones in the same cycle dropped.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    level_d   = level_q;
    lvl_rst_d = 1'b0;
    unique case (state_q)
      IDLE, OVER: begin
        if (press_c) begin
          state_d   = PLAY;
          lives_d   = LivesInit;
          level_d   = '0;
          lvl_rst_d = 1'b1;
        end
      end
      PLAY: begin
        if (invaded_i) begin
          state_d = OVER;
          lives_d = '0;
        end else if (hit_i) begin
          if (lives_q <= LivesW'(1)) begin
            state_d = OVER;
            lives_d = '0;
          end else begin
            state_d = HIT_PAUSE;
            lives_d = lives_q - LivesW'(1);
          end
        end else if (cleared_i) begin
          state_d = (level_q >= LastLevel) ? WON : LVL_DONE;
        end
      end
      HIT_PAUSE: begin
        if (press_c) begin
          state_d = PLAY;
        end
      end
      LVL_DONE: begin
        if (press_c) begin
          state_d   = PLAY;
          lvl_rst_d = 1'b1;
          if (level_q < LastLevel) begin
            level_d = level_q + LevelW'(1);
          end
        end
      end
      WON: begin
        state_d = WON;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ship blink while paused after a hit, plus state-decoded status outputs.
  always_comb begin
    flash_d  = '0;
    vis_d    = 1'b1;
    if ((state_q == HIT_PAUSE) && (state_d == HIT_PAUSE)) begin
      if (flash_q == FlashLast) begin
        flash_d = '0;
        vis_d   = ~vis_q;
      end else begin
        flash_d = flash_q + FlashW'(1);
        vis_d   = vis_q;
      end
    end else begin
      vis_d = (state_d != OVER);
    end
    freeze_d = (state_d != PLAY);
    alive_d  = (lives_d != '0);
    over_d   = (state_d == OVER);
    won_d    = (state_d == WON);
  end

  assign state_o        = state_q;
  assign freeze_o       = freeze_q;
  assign level_reset_o  = lvl_rst_q;
  assign lives_o        = lives_q;
  assign level_o        = level_q;
  assign alive_o        = alive_q;
  assign ship_visible_o = vis_q;
  assign game_over_o    = over_q;
  assign game_won_o     = won_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with hand-computed expectations.
module tb_game_flow_ctrl;

  localparam int unsigned LivesP  = 3;
  localparam int unsigned LevelsP = 2;
  localparam int unsigned FlashP  = 4;

  localparam logic [5:0] S_IDLE  = 6'b000001;
  localparam logic [5:0] S_PLAY  = 6'b000010;
  localparam logic [5:0] S_HIT   = 6'b000100;
  localparam logic [5:0] S_LVL   = 6'b001000;
  localparam logic [5:0] S_OVER  = 6'b010000;
  localparam logic [5:0] S_WON   = 6'b100000;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic       shoot_i;
  logic       hit_i;
  logic       cleared_i;
  logic       invaded_i;
  logic       freeze_o;
  logic       level_reset_o;
  logic [2:0] lives_o;
  logic [1:0] level_o;
  logic       alive_o;
  logic       ship_visible_o;
  logic       game_over_o;
  logic       game_won_o;
  logic [5:0] state_o;

  int n_checks = 0;
  int n_fails  = 0;

  game_flow_ctrl #(
    .lives_p        (LivesP),
    .levels_p       (LevelsP),
    .flash_cycles_p (FlashP)
  ) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .shoot_i        (shoot_i),
    .hit_i          (hit_i),
    .cleared_i      (cleared_i),
    .invaded_i      (invaded_i),
    .freeze_o       (freeze_o),
    .level_reset_o  (level_reset_o),
    .lives_o        (lives_o),
    .level_o        (level_o),
    .alive_o        (alive_o),
    .ship_visible_o (ship_visible_o),
    .game_over_o    (game_over_o),
    .game_won_o     (game_won_o),
    .state_o        (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Bound the run in case the bench itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Guarantee a low cycle then present a rising edge; shoot drops afterwards.
  task automatic press();
    shoot_i = 1'b0;
    tick();
    shoot_i = 1'b1;
    tick();
    shoot_i = 1'b0;
  endtask

  task automatic pulse_hit();
    hit_i = 1'b1;
    tick();
    hit_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_state"},  32'(state_o), 32'(S_IDLE));
    check_eq({tag, "_freeze"}, 32'(freeze_o), 32'd1);
    check_eq({tag, "_lrst"},   32'(level_reset_o), 32'd0);
    check_eq({tag, "_lives"},  32'(lives_o), 32'd3);
    check_eq({tag, "_level"},  32'(level_o), 32'd0);
    check_eq({tag, "_alive"},  32'(alive_o), 32'd1);
    check_eq({tag, "_vis"},    32'(ship_visible_o), 32'd1);
    check_eq({tag, "_over"},   32'(game_over_o), 32'd0);
    check_eq({tag, "_won"},    32'(game_won_o), 32'd0);
  endtask

  initial begin
    logic [8:0] blink;
    blink     = 9'b100001111;  // index 0 = entry cycle, read LSB first
    reset_ni  = 1'b0;
    shoot_i   = 1'b1;
    hit_i     = 1'b0;
    cleared_i = 1'b0;
    invaded_i = 1'b0;

    // Scenario 1: button held through reset is not a press.
    tick();
    tick();
    check_reset_vals("rst");
    reset_ni = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_eq("held_state", 32'(state_o), 32'(S_IDLE));
    check_eq("held_freeze", 32'(freeze_o), 32'd1);
    press();
    check_eq("start_state", 32'(state_o), 32'(S_PLAY));
    check_eq("start_lrst", 32'(level_reset_o), 32'd1);
    check_eq("start_lives", 32'(lives_o), 32'd3);
    check_eq("start_level", 32'(level_o), 32'd0);
    check_eq("start_freeze", 32'(freeze_o), 32'd0);
    tick();
    check_eq("start_lrst_drop", 32'(level_reset_o), 32'd0);

    // Scenario 2: hit, blink pattern, resume without level reset.
    pulse_hit();
    check_eq("hit1_state", 32'(state_o), 32'(S_HIT));
    check_eq("hit1_lives", 32'(lives_o), 32'd2);
    check_eq("hit1_freeze", 32'(freeze_o), 32'd1);
    for (int i = 0; i < 9; i++) begin
      check_eq($sformatf("blink%0d", i), 32'(ship_visible_o), 32'(blink[i]));
      if (i < 8) tick();
    end
    check_eq("blink_still_paused", 32'(state_o), 32'(S_HIT));
    press();
    check_eq("resume_state", 32'(state_o), 32'(S_PLAY));
    check_eq("resume_lrst", 32'(level_reset_o), 32'd0);
    check_eq("resume_vis", 32'(ship_visible_o), 32'd1);
    check_eq("resume_lives", 32'(lives_o), 32'd2);

    // Scenario 3: remaining hits end the game; press restarts.
    pulse_hit();
    check_eq("hit2_lives", 32'(lives_o), 32'd1);
    press();
    pulse_hit();
    check_eq("over_state", 32'(state_o), 32'(S_OVER));
    check_eq("over_lives", 32'(lives_o), 32'd0);
    check_eq("over_alive", 32'(alive_o), 32'd0);
    check_eq("over_vis", 32'(ship_visible_o), 32'd0);
    check_eq("over_flag", 32'(game_over_o), 32'd1);
    press();
    check_eq("restart_state", 32'(state_o), 32'(S_PLAY));
    check_eq("restart_lives", 32'(lives_o), 32'd3);
    check_eq("restart_level", 32'(level_o), 32'd0);
    check_eq("restart_lrst", 32'(level_reset_o), 32'd1);
    check_eq("restart_over", 32'(game_over_o), 32'd0);
    check_eq("restart_alive", 32'(alive_o), 32'd1);

    // Scenario 4: hit beats cleared; invaded ignored while paused.
    hit_i = 1'b1;
    cleared_i = 1'b1;
    tick();
    hit_i = 1'b0;
    cleared_i = 1'b0;
    check_eq("prio_state", 32'(state_o), 32'(S_HIT));
    check_eq("prio_lives", 32'(lives_o), 32'd2);
    check_eq("prio_level", 32'(level_o), 32'd0);
    invaded_i = 1'b1;
    tick();
    tick();
    invaded_i = 1'b0;
    check_eq("inv_ign_state", 32'(state_o), 32'(S_HIT));
    check_eq("inv_ign_over", 32'(game_over_o), 32'd0);
    press();

    // Scenario 5: clear both levels, WON absorbs, async reset exits.
    cleared_i = 1'b1;
    tick();
    cleared_i = 1'b0;
    check_eq("lvl_state", 32'(state_o), 32'(S_LVL));
    check_eq("lvl_vis", 32'(ship_visible_o), 32'd1);
    press();
    check_eq("lvl1_level", 32'(level_o), 32'd1);
    check_eq("lvl1_lrst", 32'(level_reset_o), 32'd1);
    check_eq("lvl1_lives", 32'(lives_o), 32'd2);
    cleared_i = 1'b1;
    tick();
    cleared_i = 1'b0;
    check_eq("won_state", 32'(state_o), 32'(S_WON));
    check_eq("won_flag", 32'(game_won_o), 32'd1);
    press();
    pulse_hit();
    check_eq("won_absorb", 32'(state_o), 32'(S_WON));
    check_eq("won_level", 32'(level_o), 32'd1);
    reset_ni = 1'b0;
    #1;
    check_reset_vals("async_won");
    tick();
    reset_ni = 1'b1;

    // Scenario 6: reset mid-pause with flash counter at 2.
    press();
    check_eq("s6_play", 32'(state_o), 32'(S_PLAY));
    pulse_hit();
    tick();
    tick();
    check_eq("s6_paused", 32'(state_o), 32'(S_HIT));
    reset_ni = 1'b0;
    #1;
    check_reset_vals("async_hit");
    tick();
    reset_ni = 1'b1;
    press();
    check_eq("s6_start_state", 32'(state_o), 32'(S_PLAY));
    check_eq("s6_start_lrst", 32'(level_reset_o), 32'd1);
    check_eq("s6_start_lives", 32'(lives_o), 32'd3);

    // Invaded outranks everything in PLAY.
    tick();
    invaded_i = 1'b1;
    hit_i     = 1'b1;
    cleared_i = 1'b1;
    tick();
    invaded_i = 1'b0;
    hit_i     = 1'b0;
    cleared_i = 1'b0;
    check_eq("inv_state", 32'(state_o), 32'(S_OVER));
    check_eq("inv_lives", 32'(lives_o), 32'd0);
    check_eq("inv_level", 32'(level_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
